network_interface: RTL and testbench
====================================

# network_interface

Local-port endpoint of the mesh router, i.e. the network interface (NI) that every router's local port connects to. The injection side takes payload words from the core over a valid/ready stream, wraps them into HEAD/BODY/TAIL flits and drives the router's local input under credit-based flow control. The ejection side receives local-port output flits, strips headers, reassembles packet boundaries and flags misrouted or malformed traffic.

## Interface
- `NUM_ROUTERS`, 16, mesh size.
- `ROUTER_ID`, 0, ID of the attached router.
- `CREDITS`, 4, local-input buffer slots granted to this NI.
- `ROUTER_ID_BITS`, `$clog2(NUM_ROUTERS)`, ID field width.
- `PAYLOAD_W`, `` `FLIT_DATA_WIDTH-2*ROUTER_ID_BITS-2 ``, payload bits per flit.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `core_valid` in 1: injection word valid.
- `core_ready` out 1: NI accepts word this cycle.
- `core_data` in PAYLOAD_W: payload word.
- `core_dest` in ROUTER_ID_BITS: destination router. Sampled on the first word of a packet only.
- `core_last` in 1: last word of the packet.
- `inj_data` out `FLIT_DATA_WIDTH`: flit to the router's local `input_data`.
- `inj_valid` out 1: flit valid, to the router's local `input_valid`.
- `credit_return` in 1: one-cycle pulse; the router freed one local-input slot.
- `ej_data_in` in `FLIT_DATA_WIDTH`: router local `out_data`.
- `ej_valid_in` in 1: router local `out_valid`.
- `ej_valid` out 1: ejected word valid.
- `ej_payload` out PAYLOAD_W: ejected payload.
- `ej_src` out ROUTER_ID_BITS: source router of the packet.
- `ej_last` out 1: last word of the packet.
- `err_misroute` out 1: sticky; a flit arrived with dest ≠ ROUTER_ID.
- `err_protocol` out 1: sticky; illegal flit-type sequence.
- `err_credit` out 1: sticky; credit returned while the counter is at CREDITS.
- `pkt_rx_count` out 16: count of completed received packets; wraps at 2^16.

## Operation
- Flit format, MSB first: `{dest[ROUTER_ID_BITS], src[ROUTER_ID_BITS], type[2], payload[PAYLOAD_W]}`.
  - `dest` occupies the top bits, which the router's route compute decodes.
  - Type encoding: HEAD=0, BODY=1, TAIL=2, HEADTAIL=3.
- Injection FSM, states I_IDLE and I_PKT.
  - Handshake occurs when `core_valid && core_ready`.
  - In I_IDLE, a handshake latches `core_dest` into `dest_q`. The flit type is HEAD, or HEADTAIL if `core_last` is set.
    - Next state is I_PKT if `!core_last`, otherwise stays I_IDLE.
  - In I_PKT, flit type is BODY, or TAIL on `core_last`. TAIL returns the FSM to I_IDLE.
  - `core_dest` is ignored in I_PKT.
  - `src` is always `ROUTER_ID`.
- Credit counter:
  - Width `$clog2(CREDITS+1)`; resets to CREDITS.
  - `core_ready = (credit_cnt != 0)`.
  - A handshake decrements the counter; `credit_return` increments it. When both occur in the same cycle, the count is unchanged.
  - A `credit_return` with count == CREDITS and no handshake in that cycle holds the count and sets `err_credit`.
- Ejection FSM, states E_IDLE and E_PKT. Acts only when `ej_valid_in` is asserted.
  - HEAD: latch `src` into `src_q`, go to E_PKT.
  - HEADTAIL: single-word packet, stay in E_IDLE.
  - BODY/TAIL in E_PKT: emit the word; TAIL returns to E_IDLE.
  - BODY or TAIL in E_IDLE: set `err_protocol`, drop the flit.
  - HEAD or HEADTAIL in E_PKT: set `err_protocol`, treat the flit as a new packet (the previous packet is abandoned, not counted).
  - dest ≠ ROUTER_ID: set `err_misroute`, still deliver the flit.
  - Each emitted TAIL or HEADTAIL increments `pkt_rx_count`.
  - `ej_src` is taken from the flit on HEAD/HEADTAIL, and from `src_q` otherwise.
- The ejection side has no backpressure; the core must sink one word per cycle.

## Timing
- All outputs are registered except `core_ready`, which is combinational from the counter.
- Injection latency: handshake at edge N produces `inj_valid` high for exactly the cycle after edge N.
- Sustained injection rate is one flit per cycle while credits are non-zero.
- A returned credit is usable in the cycle after its `credit_return` pulse.
- Ejection latency: flit in on cycle N → `ej_valid`/`ej_payload` in cycle N+1. Error flags and `pkt_rx_count` update on the same edge.
- Reset values:
  - All outputs 0, except `credit_cnt = CREDITS`, so `core_ready` = 1 after reset.
  - Both FSMs in IDLE.
  - Sticky errors clear only on reset.
- Reset asserted mid-packet aborts the packet immediately; no partial TAIL is emitted.

## Structure
- Shared package `noc_pkg`:
  - `flit_type_e` enum.
  - `flit_t` packed struct (dest, src, type, payload) parameterised by `ROUTER_ID_BITS`.
  - `FLIT_DATA_WIDTH` constant.
- Sub-module `credit_counter`: parameter CREDITS; inputs `consume`, `ret`; outputs `count`, `nonzero`, `overflow`. Reusable by the router's non-local output ports.
- Injection and ejection FSMs live in `network_interface` itself.

## Test plan
- Single-word packet, core_dest=5, core_last=1, ROUTER_ID=0 → one flit, dest=5, src=0, type=3, next cycle; credit_cnt 4→3.
- 3-word packet, core_dest=9 on word 1, then 2 and 7 on later words → types 0,1,2, all dest=9 over 3 consecutive cycles.
- No credit_return, 6 words offered, CREDITS=4 → 4 accepted, `core_ready` low; one return pulse → 5th accepted next cycle.
- Simultaneous handshake and credit_return at count 2 → count stays 2. Return at count 4 with no handshake → `err_credit`=1, count stays 4.
- Ejection sequence HEAD(src=3), BODY, TAIL → ej_src=3 on all three words, ej_last on the third, pkt_rx_count=1. Then a lone BODY → dropped, `err_protocol`=1. Then a flit with dest=2 → delivered, `err_misroute`=1.
- Reset asserted mid 3-word packet → inj_valid=0, credit_cnt=4, I_IDLE. The next word is sent as HEAD.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit types and NI FSM states.
// Used by the network interface and the router ports.
package noc_pkg;

    localparam int FLIT_DATA_WIDTH = 32;
    localparam int NOC_ID_BITS = 4;
    localparam int NOC_PAYLOAD_W = FLIT_DATA_WIDTH - 2 * NOC_ID_BITS - 2;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_e;

    typedef struct packed {
        logic [NOC_ID_BITS-1:0]   dest;
        logic [NOC_ID_BITS-1:0]   src;
        flit_type_e               ftype;
        logic [NOC_PAYLOAD_W-1:0] payload;
    } flit_t;

    typedef enum logic {
        I_IDLE = 1'b0,
        I_PKT  = 1'b1
    } inj_state_e;

    typedef enum logic {
        E_IDLE = 1'b0,
        E_PKT  = 1'b1
    } ej_state_e;

endpackage

// File: rtl/credit_counter.sv
// Credit counter for one downstream buffer; starts full, flags
// returns that would exceed the granted number of slots.
module credit_counter #(
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          consume,
    input  logic          ret,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          overflow
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    assign nonzero  = (count != '0);
    assign overflow = ret && !consume && (count == FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= FULL;
        end else if (consume && !ret) begin
            count <= count - 1'b1;
        end else if (ret && !consume && !overflow) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/network_interface.sv
// Local-port network interface: packetises core words into flits
// and reassembles ejected flits, flagging bad traffic.
module network_interface
    import noc_pkg::*;
#(
    parameter int NUM_ROUTERS    = 16,
    parameter int ROUTER_ID      = 0,
    parameter int CREDITS        = 4,
    parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
    parameter int PAYLOAD_W      = FLIT_DATA_WIDTH - 2 * ROUTER_ID_BITS - 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       core_valid,
    output logic                       core_ready,
    input  logic [PAYLOAD_W-1:0]       core_data,
    input  logic [ROUTER_ID_BITS-1:0]  core_dest,
    input  logic                       core_last,
    output logic [FLIT_DATA_WIDTH-1:0] inj_data,
    output logic                       inj_valid,
    input  logic                       credit_return,
    input  logic [FLIT_DATA_WIDTH-1:0] ej_data_in,
    input  logic                       ej_valid_in,
    output logic                       ej_valid,
    output logic [PAYLOAD_W-1:0]       ej_payload,
    output logic [ROUTER_ID_BITS-1:0]  ej_src,
    output logic                       ej_last,
    output logic                       err_misroute,
    output logic                       err_protocol,
    output logic                       err_credit,
    output logic [15:0]                pkt_rx_count
);

    localparam int FW = FLIT_DATA_WIDTH;
    localparam int RB = ROUTER_ID_BITS;
    localparam int PW = PAYLOAD_W;
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [RB-1:0] MY_ID = RB'(ROUTER_ID);

    logic          hs;
    logic          credit_ovf;
    logic [CW-1:0] credit_cnt;

    assign hs = core_valid && core_ready;

    credit_counter #(
        .CREDITS(CREDITS)
    ) u_credit (
        .clk     (clk),
        .reset   (reset),
        .consume (hs),
        .ret     (credit_return),
        .count   (credit_cnt),
        .nonzero (core_ready),
        .overflow(credit_ovf)
    );

    inj_state_e    inj_st;
    logic [RB-1:0] dest_q;
    logic [RB-1:0] inj_dest;
    flit_type_e    inj_type;

    always_comb begin
        inj_dest = core_dest;
        inj_type = HEAD;
        if (inj_st == I_IDLE) begin
            inj_dest = core_dest;
            inj_type = core_last ? HEADTAIL : HEAD;
        end else begin
            inj_dest = dest_q;
            inj_type = core_last ? TAIL : BODY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inj_st     <= I_IDLE;
            dest_q     <= '0;
            inj_valid  <= 1'b0;
            inj_data   <= '0;
            err_credit <= 1'b0;
        end else begin
            inj_valid <= hs;
            if (hs) begin
                inj_data <= {inj_dest, MY_ID, inj_type, core_data};
                if (inj_st == I_IDLE) begin
                    dest_q <= core_dest;
                end
                inj_st <= core_last ? I_IDLE : I_PKT;
            end
            if (credit_ovf) begin
                err_credit <= 1'b1;
            end
        end
    end

    ej_state_e     ej_st;
    logic [RB-1:0] src_q;
    logic [RB-1:0] e_dest;
    logic [RB-1:0] e_src;
    flit_type_e    e_type;
    logic [PW-1:0] e_pay;

    assign e_dest = ej_data_in[FW-1 -: RB];
    assign e_src  = ej_data_in[FW-1-RB -: RB];
    assign e_type = flit_type_e'(ej_data_in[PW+1:PW]);
    assign e_pay  = ej_data_in[PW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ej_st        <= E_IDLE;
            src_q        <= '0;
            ej_valid     <= 1'b0;
            ej_payload   <= '0;
            ej_src       <= '0;
            ej_last      <= 1'b0;
            err_misroute <= 1'b0;
            err_protocol <= 1'b0;
            pkt_rx_count <= '0;
        end else begin
            ej_valid <= 1'b0;
            ej_last  <= 1'b0;
            if (ej_valid_in) begin
                if (e_dest != MY_ID) begin
                    err_misroute <= 1'b1;
                end
                unique case (e_type)
                    HEAD: begin
                        // an open packet is abandoned, not counted
                        if (ej_st == E_PKT) err_protocol <= 1'b1;
                        src_q      <= e_src;
                        ej_st      <= E_PKT;
                        ej_valid   <= 1'b1;
                        ej_payload <= e_pay;
                        ej_src     <= e_src;
                    end
                    HEADTAIL: begin
                        if (ej_st == E_PKT) err_protocol <= 1'b1;
                        ej_st        <= E_IDLE;
                        ej_valid     <= 1'b1;
                        ej_last      <= 1'b1;
                        ej_payload   <= e_pay;
                        ej_src       <= e_src;
                        pkt_rx_count <= pkt_rx_count + 16'd1;
                    end
                    BODY: begin
                        if (ej_st == E_PKT) begin
                            ej_valid   <= 1'b1;
                            ej_payload <= e_pay;
                            ej_src     <= src_q;
                        end else begin
                            err_protocol <= 1'b1;
                        end
                    end
                    TAIL: begin
                        if (ej_st == E_PKT) begin
                            ej_st        <= E_IDLE;
                            ej_valid     <= 1'b1;
                            ej_last      <= 1'b1;
                            ej_payload   <= e_pay;
                            ej_src       <= src_q;
                            pkt_rx_count <= pkt_rx_count + 16'd1;
                        end else begin
                            err_protocol <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_network_interface.sv
// Directed self-checking bench for network_interface (default params:
// 16 routers, ID 0, 4 credits, 32-bit flits, 22-bit payload).
module tb_network_interface;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_valid = 1'b0;
    logic        core_ready;
    logic [21:0] core_data = '0;
    logic [3:0]  core_dest = '0;
    logic        core_last = 1'b0;
    logic [31:0] inj_data;
    logic        inj_valid;
    logic        credit_return = 1'b0;
    logic [31:0] ej_data_in = '0;
    logic        ej_valid_in = 1'b0;
    logic        ej_valid;
    logic [21:0] ej_payload;
    logic [3:0]  ej_src;
    logic        ej_last;
    logic        err_misroute;
    logic        err_protocol;
    logic        err_credit;
    logic [15:0] pkt_rx_count;

    int checks = 0;
    int errors = 0;

    network_interface dut (
        .clk          (clk),
        .reset        (reset),
        .core_valid   (core_valid),
        .core_ready   (core_ready),
        .core_data    (core_data),
        .core_dest    (core_dest),
        .core_last    (core_last),
        .inj_data     (inj_data),
        .inj_valid    (inj_valid),
        .credit_return(credit_return),
        .ej_data_in   (ej_data_in),
        .ej_valid_in  (ej_valid_in),
        .ej_valid     (ej_valid),
        .ej_payload   (ej_payload),
        .ej_src       (ej_src),
        .ej_last      (ej_last),
        .err_misroute (err_misroute),
        .err_protocol (err_protocol),
        .err_credit   (err_credit),
        .pkt_rx_count (pkt_rx_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] d, input logic [3:0] s,
                                       input logic [1:0] t, input logic [21:0] p);
        return {d, s, t, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ret_credits(input int n);
        for (int i = 0; i < n; i++) begin
            credit_return = 1'b1;
            step();
        end
        credit_return = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        chk("rst_inj_valid", 64'(inj_valid), 64'(0));
        chk("rst_core_ready", 64'(core_ready), 64'(1));
        chk("rst_credit_cnt", 64'(dut.credit_cnt), 64'(4));
        chk("rst_ej_valid", 64'(ej_valid), 64'(0));
        chk("rst_errs", 64'({err_misroute, err_protocol, err_credit}), 64'(0));
        chk("rst_rx_count", 64'(pkt_rx_count), 64'(0));
        reset = 1'b1;
        step();

        // single-word packet
        core_valid = 1'b1; core_data = 22'h1234; core_dest = 4'd5; core_last = 1'b1;
        step();
        core_valid = 1'b0;
        chk("sw_valid", 64'(inj_valid), 64'(1));
        chk("sw_data", 64'(inj_data), 64'(mk(4'd5, 4'd0, 2'd3, 22'h1234)));
        chk("sw_cnt", 64'(dut.credit_cnt), 64'(3));
        step();
        chk("sw_valid_drop", 64'(inj_valid), 64'(0));
        ret_credits(1);
        chk("sw_cnt_back", 64'(dut.credit_cnt), 64'(4));

        // 3-word packet, dest changes ignored after the head
        core_valid = 1'b1; core_last = 1'b0; core_dest = 4'd9; core_data = 22'h0000a;
        step();
        chk("p3_head", 64'(inj_data), 64'(mk(4'd9, 4'd0, 2'd0, 22'h0000a)));
        chk("p3_state", 64'(dut.inj_st), 64'(I_PKT));
        core_dest = 4'd2; core_data = 22'h0000b;
        step();
        chk("p3_body", 64'(inj_data), 64'(mk(4'd9, 4'd0, 2'd1, 22'h0000b)));
        chk("p3_body_v", 64'(inj_valid), 64'(1));
        core_dest = 4'd7; core_data = 22'h0000c; core_last = 1'b1;
        step();
        chk("p3_tail", 64'(inj_data), 64'(mk(4'd9, 4'd0, 2'd2, 22'h0000c)));
        chk("p3_idle", 64'(dut.inj_st), 64'(I_IDLE));
        core_valid = 1'b0;
        ret_credits(3);
        chk("p3_cnt_back", 64'(dut.credit_cnt), 64'(4));

        // credit exhaustion: 6 words offered, 4 accepted
        core_valid = 1'b1; core_last = 1'b1; core_dest = 4'd1;
        for (int i = 0; i < 6; i++) begin
            core_data = 22'(i);
            chk($sformatf("ex_ready%0d", i), 64'(core_ready), 64'(i < 4));
            step();
            chk($sformatf("ex_inj%0d", i), 64'(inj_valid), 64'(i < 4));
        end
        chk("ex_cnt0", 64'(dut.credit_cnt), 64'(0));
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        chk("ex_ret_cnt", 64'(dut.credit_cnt), 64'(1));
        chk("ex_ret_ready", 64'(core_ready), 64'(1));
        core_data = 22'h3ffff;
        step();
        core_valid = 1'b0;
        chk("ex_5th", 64'(inj_data), 64'(mk(4'd1, 4'd0, 2'd3, 22'h3ffff)));
        chk("ex_5th_cnt", 64'(dut.credit_cnt), 64'(0));

        // simultaneous consume and return at count 2
        ret_credits(2);
        chk("sim_pre", 64'(dut.credit_cnt), 64'(2));
        core_valid = 1'b1; credit_return = 1'b1;
        step();
        core_valid = 1'b0; credit_return = 1'b0;
        chk("sim_cnt", 64'(dut.credit_cnt), 64'(2));
        chk("sim_inj", 64'(inj_valid), 64'(1));
        ret_credits(2);
        chk("ovf_pre", 64'(err_credit), 64'(0));
        ret_credits(1);
        chk("ovf_err", 64'(err_credit), 64'(1));
        chk("ovf_cnt", 64'(dut.credit_cnt), 64'(4));
        step();
        chk("ovf_sticky", 64'(err_credit), 64'(1));

        // ejection: HEAD/BODY/TAIL from router 3
        ej_valid_in = 1'b1;
        ej_data_in = mk(4'd0, 4'd3, 2'd0, 22'h11);
        step();
        chk("ej_h_v", 64'(ej_valid), 64'(1));
        chk("ej_h", 64'({ej_src, ej_last, ej_payload}), 64'({4'd3, 1'b0, 22'h11}));
        ej_data_in = mk(4'd0, 4'd6, 2'd1, 22'h22);
        step();
        chk("ej_b", 64'({ej_valid, ej_src, ej_last, ej_payload}),
            64'({1'b1, 4'd3, 1'b0, 22'h22}));
        ej_data_in = mk(4'd0, 4'd6, 2'd2, 22'h33);
        step();
        chk("ej_t", 64'({ej_valid, ej_src, ej_last, ej_payload}),
            64'({1'b1, 4'd3, 1'b1, 22'h33}));
        chk("ej_t_cnt", 64'(pkt_rx_count), 64'(1));
        chk("ej_t_perr", 64'(err_protocol), 64'(0));
        ej_data_in = mk(4'd0, 4'd3, 2'd1, 22'h44);
        step();
        chk("ej_lone_v", 64'(ej_valid), 64'(0));
        chk("ej_lone_perr", 64'(err_protocol), 64'(1));
        chk("ej_lone_cnt", 64'(pkt_rx_count), 64'(1));
        chk("ej_lone_mis", 64'(err_misroute), 64'(0));
        ej_data_in = mk(4'd2, 4'd1, 2'd3, 22'h55);
        step();
        chk("ej_mis", 64'({ej_valid, ej_src, ej_last, ej_payload}),
            64'({1'b1, 4'd1, 1'b1, 22'h55}));
        chk("ej_mis_err", 64'(err_misroute), 64'(1));
        chk("ej_mis_cnt", 64'(pkt_rx_count), 64'(2));
        ej_valid_in = 1'b0;
        step();
        chk("ej_idle_v", 64'(ej_valid), 64'(0));

        // reset mid-packet
        core_valid = 1'b1; core_last = 1'b0; core_dest = 4'd9; core_data = 22'h1;
        step();
        core_data = 22'h2;
        step();
        chk("mid_cnt", 64'(dut.credit_cnt), 64'(2));
        chk("mid_state", 64'(dut.inj_st), 64'(I_PKT));
        reset = 1'b0;
        #1;
        chk("mid_rst_inj", 64'(inj_valid), 64'(0));
        chk("mid_rst_cnt", 64'(dut.credit_cnt), 64'(4));
        chk("mid_rst_state", 64'(dut.inj_st), 64'(I_IDLE));
        chk("mid_rst_errs", 64'({err_misroute, err_protocol, err_credit}), 64'(0));
        chk("mid_rst_rx", 64'(pkt_rx_count), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        core_dest = 4'd3; core_data = 22'h5;
        step();
        chk("post_head", 64'(inj_data), 64'(mk(4'd3, 4'd0, 2'd0, 22'h5)));
        chk("post_head_v", 64'(inj_valid), 64'(1));
        core_dest = 4'd8; core_last = 1'b1; core_data = 22'h6;
        step();
        core_valid = 1'b0;
        chk("post_tail", 64'(inj_data), 64'(mk(4'd3, 4'd0, 2'd2, 22'h6)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
